// File: rtl/sigma_delta_pkg.sv
// Shared defaults and the width helper for the sigma-delta ADC front end.
package sigma_delta_pkg;

  localparam int BOSR_DEF = 256;
  localparam int STGS_DEF = 2;

  // Accumulator width that holds the full CIC gain BOSR^STGS without loss.
  function automatic int cic_width(input int bosr, input int stgs);
    return 2 + stgs * $clog2(bosr);
  endfunction

endpackage

// File: rtl/cic_decimator.sv
// STGS-order CIC decimator: integrators at the bit rate, combs at the
// decimated rate, unsigned output with a one-cycle valid strobe.
module cic_decimator
  import sigma_delta_pkg::*;
#(
  parameter int BOSR = BOSR_DEF,
  parameter int STGS = STGS_DEF,
  parameter int WDTH = cic_width(BOSR, STGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bit_in,
  output logic [WDTH-1:0] adc_output,
  output logic            adc_valid
);

  localparam int CW = $clog2(BOSR);

  logic [WDTH-1:0] x;
  logic [CW-1:0]   cnt;
  logic            dec;

  assign x   = {{(WDTH-1){1'b0}}, bit_in};
  assign dec = (cnt == CW'(BOSR - 1));

  // Integrator chain; modulo-2^WDTH wrap is relied on by the combs.
  for (genvar k = 0; k < STGS; k++) begin : g_int
    logic [WDTH-1:0] acc;
    logic [WDTH-1:0] acc_in;

    if (k == 0) begin : g_first
      assign acc_in = x;
    end else begin : g_next
      assign acc_in = g_int[k-1].acc;
    end

    // Accumulate the registered previous-stage value every clock.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) acc <= '0;
      else     acc <= acc + acc_in;
    end
  end

  // Decimation phase counter; BOSR is a power of two so it wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + CW'(1);
  end

  // Comb chain, differential delay 1, advanced only on decimated samples.
  for (genvar k = 0; k < STGS; k++) begin : g_comb
    logic [WDTH-1:0] diff_in;
    logic [WDTH-1:0] dly;
    logic [WDTH-1:0] diff;

    if (k == 0) begin : g_first
      assign diff_in = g_int[STGS-1].acc;
    end else begin : g_next
      assign diff_in = g_comb[k-1].diff;
    end

    assign diff = diff_in - dly;

    // Remember this stage's input from the previous decimated sample.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)      dly <= '0;
      else if (dec) dly <= diff_in;
    end
  end

  // Register the comb result and strobe valid on the decimation cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_output <= '0;
      adc_valid  <= 1'b0;
    end else begin
      adc_valid <= dec;
      if (dec) adc_output <= g_comb[STGS-1].diff;
    end
  end

endmodule

// File: rtl/sigma_delta_adc.sv
// First-order sigma-delta ADC front end: comparator sampling flop that also
// drives the integrator feedback pin, followed by the CIC decimator.
module sigma_delta_adc
  import sigma_delta_pkg::*;
#(
  parameter int BOSR = BOSR_DEF,
  parameter int STGS = STGS_DEF,
  parameter int WDTH = cic_width(BOSR, STGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adc_lvds_pin,
  output logic            adc_fb_pin,
  output logic [WDTH-1:0] adc_output,
  output logic            adc_valid
);

  logic q;

  // Modulator bit: sample the comparator once per bit clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= adc_lvds_pin;
  end

  // Feedback comes straight off the flop so the pin is glitch-free.
  assign adc_fb_pin = q;

  cic_decimator #(
    .BOSR (BOSR),
    .STGS (STGS),
    .WDTH (WDTH)
  ) u_cic (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (q),
    .adc_output (adc_output),
    .adc_valid  (adc_valid)
  );

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Bench for sigma_delta_adc: default instance with a queue scoreboard plus a
// BOSR=64/STGS=3 instance held at full scale.
module tb_sigma_delta_adc;
  import sigma_delta_pkg::*;

  localparam int  BOSR   = 256;
  localparam int  STGS   = 2;
  localparam int  WDTH   = cic_width(BOSR, STGS);
  localparam int  FULL   = BOSR ** STGS;
  localparam int  BOSR_B = 64;
  localparam int  STGS_B = 3;
  localparam int  WDTH_B = cic_width(BOSR_B, STGS_B);
  localparam int  FULL_B = BOSR_B ** STGS_B;
  localparam real VCC    = 2.5;

  logic              clk;
  logic              rst;
  logic              adc_lvds_pin;
  logic              adc_fb_pin;
  logic [WDTH-1:0]   adc_output;
  logic              adc_valid;
  logic              pin_b;
  logic              fb_b;
  logic [WDTH_B-1:0] out_b;
  logic              valid_b;

  typedef struct {
    bit chk;
    int lo;
    int hi;
  } exp_t;

  exp_t sb[$];

  int  n_assert = 0;
  int  n_fail   = 0;
  int  mode     = 0;
  real vin      = 0.0;
  real v        = 0.0;

  sigma_delta_adc dut (
    .clk          (clk),
    .rst          (rst),
    .adc_lvds_pin (adc_lvds_pin),
    .adc_fb_pin   (adc_fb_pin),
    .adc_output   (adc_output),
    .adc_valid    (adc_valid)
  );

  sigma_delta_adc #(.BOSR(BOSR_B), .STGS(STGS_B)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .adc_lvds_pin (pin_b),
    .adc_fb_pin   (fb_b),
    .adc_output   (out_b),
    .adc_valid    (valid_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stimulus driver: updates the comparator pin shortly after each rising edge.
  initial begin
    adc_lvds_pin = 1'b0;
    pin_b        = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0: adc_lvds_pin = 1'b0;
        1: adc_lvds_pin = 1'b1;
        2: adc_lvds_pin = ~adc_lvds_pin;
        default: begin
          if (adc_fb_pin) v = v + (VCC - v) / 128.0;
          else            v = v - v / 128.0;
          adc_lvds_pin = (vin > v);
        end
      endcase
    end
  end

  // Monitor for the default instance: timing, feedback latency, hold, scoreboard.
  initial begin
    int   since    = 0;
    logic prev_pin = 1'b0;
    logic [WDTH-1:0] last_out = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        since    = 0;
        last_out = '0;
      end else begin
        since++;
        check("fb_latency", adc_fb_pin, prev_pin);
        if (adc_valid) begin
          check("valid_period", since, BOSR);
          since = 0;
          check("sb_has_entry", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
              if (e.lo == e.hi) check("sample_exact", adc_output, e.lo);
              else check("sample_range", (adc_output >= e.lo) && (adc_output <= e.hi), 1);
            end
          end
          last_out = adc_output;
        end else begin
          check("output_hold", adc_output, last_out);
        end
      end
      prev_pin = adc_lvds_pin;
    end
  end

  // Monitor for the BOSR=64/STGS=3 instance, input tied high.
  initial begin
    int since_b  = 0;
    int pulses_b = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        since_b  = 0;
        pulses_b = 0;
      end else begin
        since_b++;
        if (valid_b) begin
          check("b_valid_period", since_b, BOSR_B);
          since_b = 0;
          pulses_b++;
          if (pulses_b >= STGS_B + 1) check("b_steady", out_b, FULL_B);
        end
      end
    end
  end

  task automatic push_frames(input int frames, input int settle, input int lo, input int hi);
    exp_t e;
    sb.delete();
    for (int i = 0; i < frames; i++) begin
      e.chk = (i >= settle);
      e.lo  = lo;
      e.hi  = hi;
      sb.push_back(e);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_fb"},      adc_fb_pin, 0);
    check({tag, "_out"},     adc_output, 0);
    check({tag, "_valid"},   adc_valid,  0);
    check({tag, "_b_out"},   out_b,      0);
    check({tag, "_b_valid"}, valid_b,    0);
  endtask

  task automatic wait_drain(input int frames);
    for (int i = 0; i < frames * BOSR && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic run_case(input int m, input real vin_v, input int frames,
                          input int settle, input int lo, input int hi);
    @(negedge clk);
    #1;
    rst          = 1'b1;
    mode         = m;
    vin          = vin_v;
    v            = 0.0;
    adc_lvds_pin = (m == 1);
    push_frames(frames, settle, lo, hi);
    #1;
    check_cleared("reset");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    wait_drain(frames + 2);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // All ones: exact full-scale gain from the third sample on.
    run_case(1, 0.0, 6, STGS, FULL, FULL);
    // All zeros: every sample is zero.
    run_case(0, 0.0, 4, 0, 0, 0);
    // Alternating bits: half scale, long enough to wrap the integrators.
    run_case(2, 0.0, 20, STGS, FULL / 2, FULL / 2);
    // Closed loop against the RC model at half and quarter of VCC.
    run_case(3, 1.25, 12, 4, FULL / 2 - FULL / 200, FULL / 2 + FULL / 200);
    run_case(3, 0.625, 12, 4, FULL / 4 - FULL / 400, FULL / 4 + FULL / 400);

    // Mid-frame reset at counter = 100 with the input high.
    run_case(1, 0.0, 4, STGS, FULL, FULL);
    repeat (100) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_cleared("midreset");
    push_frames(4, STGS, FULL, FULL);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    wait_drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
